// File: rtl/fxp_sat_shift_left.sv
// Two-stage packed-lane saturating left shifter: S1 forms double-width shifted lanes,
// S2 clamps each lane to the SEW range and tracks the sticky vxsat flag.
module fxp_sat_shift_left #(
    parameter int LEN_CSR = 64,
    parameter int SHW     = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         sew,
    input  logic               is_signed,
    input  logic [LEN_CSR-1:0] v,
    input  logic [SHW-1:0]     d,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LEN_CSR-1:0] out,
    output logic [7:0]         sat_lanes,
    input  logic               vxsat_clr,
    output logic               vxsat
);

    localparam int WW = 2 * LEN_CSR;

    logic               s2_load_s;
    logic               s1_load_s;
    logic [WW-1:0]      wide_s;
    logic [LEN_CSR-1:0] res_s;
    logic [7:0]         sat_s;
    logic [64:0]        lane_s;

    logic               s1_valid_r;
    logic [WW-1:0]      s1_wide_r;
    logic [1:0]         s1_sew_r;
    logic               s1_signed_r;

    // Clamp one 2*s-bit shifted lane to s bits; returns {overflow, clamped value}.
    // Signed lanes fit when bits [2s-1:s-1] all match the sign; unsigned when [2s-1:s] are zero.
    function automatic logic [64:0] sat_lane(input logic [127:0] w, input int unsigned s,
                                             input logic sg);
        logic        ovf;
        logic        msb;
        logic        ref_b;
        logic [63:0] mask;
        logic [63:0] half;
        logic [63:0] res;
        int unsigned lo;
        msb   = w[7'(2 * s - 32'd1)];
        ref_b = sg & msb;
        lo    = sg ? (s - 32'd1) : s;
        ovf   = 1'b0;
        for (int unsigned b = 0; b < 32'd128; b++) begin
            if ((b >= lo) && (b < 2 * s)) begin
                ovf = ovf | (w[7'(b)] ^ ref_b);
            end else begin
                ovf = ovf;
            end
        end
        mask = (s >= 32'd64) ? {64{1'b1}} : ((64'd1 << s) - 64'd1);
        half = 64'd1 << (s - 32'd1);
        if (!ovf) begin
            res = w[63:0] & mask;
        end else if (sg) begin
            res = msb ? half : (half - 64'd1);
        end else begin
            res = mask;
        end
        return {ovf, res};
    endfunction

    assign s2_load_s = s1_valid_r && (!out_valid || out_ready);
    assign in_ready  = !s1_valid_r || s2_load_s;
    assign s1_load_s = in_valid && in_ready && !flush;

    // Stage-1 datapath: extend each lane to double width and shift by d modulo SEW.
    always_comb begin
        wide_s = {WW{1'b0}};
        case (sew)
            2'b00: begin
                for (int i = 0; i < 8; i++) begin
                    wide_s[i*16 +: 16] = {{8{is_signed & v[i*8+7]}}, v[i*8 +: 8]} << d[2:0];
                end
            end
            2'b01: begin
                for (int i = 0; i < 4; i++) begin
                    wide_s[i*32 +: 32] = {{16{is_signed & v[i*16+15]}}, v[i*16 +: 16]} << d[3:0];
                end
            end
            2'b10: begin
                for (int i = 0; i < 2; i++) begin
                    wide_s[i*64 +: 64] = {{32{is_signed & v[i*32+31]}}, v[i*32 +: 32]} << d[4:0];
                end
            end
            2'b11: begin
                wide_s = {{64{is_signed & v[63]}}, v} << d[5:0];
            end
            default: begin
                wide_s = {WW{1'b0}};
            end
        endcase
    end

    // Stage-2 datapath: saturate each lane of the registered wide results.
    always_comb begin
        res_s  = {LEN_CSR{1'b0}};
        sat_s  = 8'd0;
        lane_s = 65'd0;
        case (s1_sew_r)
            2'b00: begin
                for (int i = 0; i < 8; i++) begin
                    lane_s = sat_lane({112'd0, s1_wide_r[i*16 +: 16]}, 32'd8, s1_signed_r);
                    res_s[i*8 +: 8] = lane_s[7:0];
                    sat_s[i]        = lane_s[64];
                end
            end
            2'b01: begin
                for (int i = 0; i < 4; i++) begin
                    lane_s = sat_lane({96'd0, s1_wide_r[i*32 +: 32]}, 32'd16, s1_signed_r);
                    res_s[i*16 +: 16] = lane_s[15:0];
                    sat_s[i]          = lane_s[64];
                end
            end
            2'b10: begin
                for (int i = 0; i < 2; i++) begin
                    lane_s = sat_lane({64'd0, s1_wide_r[i*64 +: 64]}, 32'd32, s1_signed_r);
                    res_s[i*32 +: 32] = lane_s[31:0];
                    sat_s[i]          = lane_s[64];
                end
            end
            2'b11: begin
                lane_s   = sat_lane(s1_wide_r, 32'd64, s1_signed_r);
                res_s    = lane_s[63:0];
                sat_s[0] = lane_s[64];
            end
            default: begin
                res_s = {LEN_CSR{1'b0}};
                sat_s = 8'd0;
            end
        endcase
    end

    // Stage-1 register: captures a beat when empty or when its occupant advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r  <= 1'b0;
            s1_wide_r   <= {WW{1'b0}};
            s1_sew_r    <= 2'b00;
            s1_signed_r <= 1'b0;
        end else if (flush) begin
            s1_valid_r <= 1'b0;
        end else if (s1_load_s) begin
            s1_valid_r  <= 1'b1;
            s1_wide_r   <= wide_s;
            s1_sew_r    <= sew;
            s1_signed_r <= is_signed;
        end else if (s2_load_s) begin
            s1_valid_r <= 1'b0;
        end else begin
            s1_valid_r <= s1_valid_r;
        end
    end

    // Stage-2 register: result and flags hold while downstream stalls or after a flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out       <= {LEN_CSR{1'b0}};
            sat_lanes <= 8'd0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (s2_load_s) begin
            out_valid <= 1'b1;
            out       <= res_s;
            sat_lanes <= sat_s;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= out_valid;
        end
    end

    // Sticky flag: only consumed, unflushed saturating beats set it; set beats clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vxsat <= 1'b0;
        end else if (out_valid && out_ready && !flush && (sat_lanes != 8'd0)) begin
            vxsat <= 1'b1;
        end else if (vxsat_clr) begin
            vxsat <= 1'b0;
        end else begin
            vxsat <= vxsat;
        end
    end

endmodule

// File: tb/tb_fxp_sat_shift_left.sv
// Self-checking bench for fxp_sat_shift_left: arithmetic reference model, scoreboard
// monitor on the falling edge, directed cases plus a randomized stream.
module tb_fxp_sat_shift_left;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  sew = 2'b00;
    logic        is_signed = 1'b0;
    logic [63:0] v = 64'd0;
    logic [5:0]  d = 6'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out;
    logic [7:0]  sat_lanes;
    logic        vxsat_clr = 1'b0;
    logic        vxsat;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [63:0] o;
        logic [7:0]  s;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    exp_t        pin_e;
    bit          mon_en = 1'b0;
    bit          stall_prev = 1'b0;
    logic [63:0] prev_out = 64'd0;
    logic [7:0]  prev_sat = 8'd0;
    logic        vx_exp = 1'b0;
    logic        saved_vx;

    fxp_sat_shift_left #(.LEN_CSR(64), .SHW(6)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .sew(sew), .is_signed(is_signed), .v(v), .d(d), .out_valid(out_valid),
        .out_ready(out_ready), .out(out), .sat_lanes(sat_lanes), .vxsat_clr(vxsat_clr),
        .vxsat(vxsat)
    );

    always #5 clk = ~clk;

    // Reference: each lane as an integer, multiplied by 2^de, clamped to the SEW range.
    function automatic exp_t model(input logic [63:0] vv, input logic [1:0] ss,
                                   input logic sg, input logic [5:0] dd);
        exp_t               e;
        int                 sw;
        int                 n;
        int                 de;
        logic [63:0]        lane;
        logic [63:0]        mask;
        logic signed [131:0] x;
        logic signed [131:0] hi;
        logic signed [131:0] lo;
        sw   = 8 << ss;
        n    = 64 / sw;
        de   = int'(dd) % sw;
        mask = (sw == 64) ? {64{1'b1}} : ((64'd1 << sw) - 64'd1);
        e.o  = 64'd0;
        e.s  = 8'd0;
        for (int i = 0; i < n; i++) begin
            lane = (vv >> (i * sw)) & mask;
            x = $signed({68'd0, lane});
            if (sg) begin
                if (lane[sw-1]) x = x - (132'sd1 <<< sw);
                hi = (132'sd1 <<< (sw - 1)) - 132'sd1;
                lo = -(132'sd1 <<< (sw - 1));
            end else begin
                hi = (132'sd1 <<< sw) - 132'sd1;
                lo = 132'sd0;
            end
            x = x * (132'sd1 <<< de);
            if (x > hi) begin
                x = hi;
                e.s[i] = 1'b1;
            end else if (x < lo) begin
                x = lo;
                e.s[i] = 1'b1;
            end
            e.o = e.o | ((x[63:0] & mask) << (i * sw));
        end
        return e;
    endfunction

    task automatic chk_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired", name);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [63:0] vv, input logic [1:0] ss, input logic sg,
                             input logic [5:0] dd);
        bit done;
        done = 1'b0;
        v = vv; sew = ss; is_signed = sg; d = dd; in_valid = 1'b1;
        for (int t = 0; t < 40 && !done; t++) begin
            if (in_ready) done = 1'b1;
            step();
        end
        in_valid = 1'b0;
        if (!done) fail_now("send_timeout");
    endtask

    task automatic run_one(input string name, input logic [63:0] vv, input logic [1:0] ss,
                           input logic sg, input logic [5:0] dd, input logic [63:0] eo,
                           input logic [7:0] es);
        out_ready = 1'b1;
        send_beat(vv, ss, sg, dd);
        chk_eq({name, "_lat1_valid"}, 64'(out_valid), 64'd0);
        step();
        chk_eq({name, "_lat2_valid"}, 64'(out_valid), 64'd1);
        chk_eq({name, "_out"}, out, eo);
        chk_eq({name, "_sat"}, 64'(sat_lanes), 64'(es));
        step();
    endtask

    // Scoreboard: mirror handshakes just before each rising edge and check results.
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            if (stall_prev) begin
                chk_eq("stall_valid", 64'(out_valid), 64'd1);
                chk_eq("stall_out", out, prev_out);
                chk_eq("stall_sat", 64'(sat_lanes), 64'(prev_sat));
            end
            chk_eq("vxsat", 64'(vxsat), 64'(vx_exp));
            if (out_valid && out_ready && !flush) begin
                if (q.size() == 0) begin
                    fail_now("extra_beat");
                end else begin
                    mon_e = q.pop_front();
                    chk_eq("sb_out", out, mon_e.o);
                    chk_eq("sb_sat", 64'(sat_lanes), 64'(mon_e.s));
                end
                if (sat_lanes != 8'd0) vx_exp = 1'b1;
                else if (vxsat_clr) vx_exp = 1'b0;
            end else if (vxsat_clr) begin
                vx_exp = 1'b0;
            end
            if (flush) q.delete();
            else if (in_valid && in_ready) q.push_back(model(v, sew, is_signed, d));
            stall_prev = out_valid && !out_ready && !flush;
            prev_out   = out;
            prev_sat   = sat_lanes;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Pin the model with hand-computed lanes.
        pin_e = model(64'h00000000_E0F01005, 2'b00, 1'b1, 6'd3);
        chk_eq("pin1_out", pin_e.o, 64'h00000000_80807F28);
        chk_eq("pin1_sat", 64'(pin_e.s), 64'h0A);
        pin_e = model(64'h00000000_00000020, 2'b00, 1'b0, 6'd11);
        chk_eq("pin2_out", pin_e.o, 64'h00000000_000000FF);
        chk_eq("pin2_sat", 64'(pin_e.s), 64'h01);
        pin_e = model(64'hC0000000_3FFFFFFF, 2'b10, 1'b1, 6'd2);
        chk_eq("pin3_out", pin_e.o, 64'h80000000_7FFFFFFF);
        chk_eq("pin3_sat", 64'(pin_e.s), 64'h03);
        pin_e = model(64'hC0000000_3FFFFFFF, 2'b10, 1'b1, 6'd1);
        chk_eq("pin4_out", pin_e.o, 64'h80000000_7FFFFFFE);
        chk_eq("pin4_sat", 64'(pin_e.s), 64'h00);

        #2;
        chk_eq("rst_out", out, 64'd0);
        chk_eq("rst_sat", 64'(sat_lanes), 64'd0);
        chk_eq("rst_valid", 64'(out_valid), 64'd0);
        chk_eq("rst_vxsat", 64'(vxsat), 64'd0);
        #10;
        rst_n = 1'b1;
        mon_en = 1'b1;
        step();
        chk_eq("rst_in_ready", 64'(in_ready), 64'd1);

        run_one("s8_signed", 64'h00000000_E0F01005, 2'b00, 1'b1, 6'd3,
                64'h00000000_80807F28, 8'h0A);
        chk_eq("s8_vxsat_set", 64'(vxsat), 64'd1);
        run_one("s8_unsigned", 64'h00000000_00000020, 2'b00, 1'b0, 6'd11,
                64'h00000000_000000FF, 8'h01);
        run_one("s32_d2", 64'hC0000000_3FFFFFFF, 2'b10, 1'b1, 6'd2,
                64'h80000000_7FFFFFFF, 8'h03);
        run_one("s32_d1", 64'hC0000000_3FFFFFFF, 2'b10, 1'b1, 6'd1,
                64'h80000000_7FFFFFFE, 8'h00);
        run_one("s32_d0", 64'hC0000000_3FFFFFFF, 2'b10, 1'b1, 6'd0,
                64'hC0000000_3FFFFFFF, 8'h00);
        chk_eq("d0_vxsat_kept", 64'(vxsat), 64'd1);
        run_one("s64_unsigned", 64'h00000000_0000_0001, 2'b11, 1'b0, 6'd63,
                64'h80000000_00000000, 8'h00);

        // Clear alone, then set-and-clear in the same cycle.
        vxsat_clr = 1'b1;
        step();
        vxsat_clr = 1'b0;
        chk_eq("clr_alone", 64'(vxsat), 64'd0);
        out_ready = 1'b1;
        send_beat(64'h00000000_E0F01005, 2'b00, 1'b1, 6'd3);
        step();
        vxsat_clr = 1'b1;
        step();
        chk_eq("set_wins", 64'(vxsat), 64'd1);
        step();
        chk_eq("clr_next", 64'(vxsat), 64'd0);
        vxsat_clr = 1'b0;

        // Back-pressure: fill both stages, hold, then release.
        out_ready = 1'b0;
        send_beat(64'h7F01_8000_1234_FFFF, 2'b01, 1'b1, 6'd5);
        send_beat(64'hFFFF_0000_8000_0001, 2'b00, 1'b0, 6'd1);
        chk_eq("bp_in_ready_low", 64'(in_ready), 64'd0);
        chk_eq("bp_out_valid", 64'(out_valid), 64'd1);
        step();
        step();
        step();
        out_ready = 1'b1;
        send_beat(64'h0123_4567_89AB_CDEF, 2'b10, 1'b0, 6'd4);
        send_beat(64'hF000_0000_0000_0001, 2'b11, 1'b1, 6'd2);
        for (int t = 0; t < 20 && (q.size() != 0 || out_valid); t++) step();
        chk_eq("bp_drained_q", 64'(q.size()), 64'd0);
        chk_eq("bp_drained_valid", 64'(out_valid), 64'd0);

        // Flush with both stages full; the beat offered during flush is dropped.
        saved_vx = vxsat;
        out_ready = 1'b0;
        send_beat(64'h0000_0000_0000_00FF, 2'b00, 1'b1, 6'd7);
        send_beat(64'h0000_0000_0000_7FFF, 2'b01, 1'b1, 6'd3);
        flush = 1'b1;
        in_valid = 1'b1;
        v = 64'h1111_1111_1111_1111;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk_eq("flush_valid", 64'(out_valid), 64'd0);
        chk_eq("flush_in_ready", 64'(in_ready), 64'd1);
        chk_eq("flush_vxsat", 64'(vxsat), 64'(saved_vx));
        out_ready = 1'b1;
        step();
        step();
        chk_eq("flush_dropped", 64'(out_valid), 64'd0);

        // Randomized stream with an asynchronous reset in the middle.
        for (int c = 0; c < 600; c++) begin
            if (c == 300) begin
                in_valid = 1'b0;
                out_ready = 1'b0;
                #2;
                mon_en = 1'b0;
                rst_n = 1'b0;
                #1;
                chk_eq("async_rst_out", out, 64'd0);
                chk_eq("async_rst_sat", 64'(sat_lanes), 64'd0);
                chk_eq("async_rst_valid", 64'(out_valid), 64'd0);
                chk_eq("async_rst_vxsat", 64'(vxsat), 64'd0);
                chk_eq("async_rst_in_ready", 64'(in_ready), 64'd1);
                q.delete();
                vx_exp = 1'b0;
                stall_prev = 1'b0;
                step();
                rst_n = 1'b1;
                mon_en = 1'b1;
            end
            in_valid  = ($urandom_range(0, 3) != 0);
            v         = {$urandom, $urandom};
            sew       = 2'($urandom_range(0, 3));
            is_signed = 1'($urandom_range(0, 1));
            d         = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(0, 63));
            out_ready = ($urandom_range(0, 3) != 0);
            vxsat_clr = ($urandom_range(0, 9) == 0);
            step();
        end
        in_valid = 1'b0;
        vxsat_clr = 1'b0;
        out_ready = 1'b1;
        for (int t = 0; t < 20 && (q.size() != 0 || out_valid); t++) step();
        chk_eq("final_drained_q", 64'(q.size()), 64'd0);
        chk_eq("final_drained_valid", 64'(out_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
